// File: rtl/satd_pkg.sv
// Shared types and constants for the SATD sequencer: stage encoding, block sizes,
// strobe vector layout and the position-to-stage mapping of the schedule.
package satd_pkg;

   localparam int N4      = 4;
   localparam int N8      = 8;
   localparam int STAGE_W = 3;
   localparam int AIDX_W  = 5;

   typedef enum logic [STAGE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_HORIZ = 3'd2,
      ST_VERT  = 3'd3,
      ST_SUM   = 3'd4,
      ST_DONE  = 3'd5
   } stage_t;

   typedef struct packed {
      logic enable_diff;
      logic shift_flag;
      logic enable_ht_horizontal;
      logic enable_shift_buffer;
      logic vertical_flag;
      logic enable_ht_vertical;
      logic end_vertical_flag;
      logic enable_absolute;
      logic enable_sum;
      logic end_sum_flag;
   } strobe_t;

   // Stage owning active-cycle index a for block size n and transform latency l.
   function automatic stage_t stage_of(input int a, input int n, input int l);
      if (a == 0)                return ST_PRIME;
      else if (a <= n)           return ST_HORIZ;
      else if (a <= 2*n)         return ST_VERT;
      else if (a <= 3*n + l + 1) return ST_SUM;
      else                       return ST_DONE;
   endfunction

   function automatic int count_of(input int a, input int n, input int l);
      case (stage_of(a, n, l))
         ST_HORIZ: return a - 1;
         ST_VERT:  return a - n - 1;
         ST_SUM:   return a - 2*n - 1;
         default:  return 0;
      endcase
   endfunction

endpackage

// File: rtl/satd_control_param_if.sv
// Handshake, status and strobe bundle between a block requester and the SATD sequencer.
interface satd_control_param_if
   import satd_pkg::*;
#(
   parameter int CNT_W = 4
);
   logic             start;
   logic             size8;
   logic             stall;
   logic             busy;
   logic             done;
   logic             size8_q;
   stage_t           stage;
   logic [CNT_W-1:0] count;
   logic             enable_diff;
   logic             shift_flag;
   logic             enable_ht_horizontal;
   logic             enable_shift_buffer;
   logic             vertical_flag;
   logic             enable_ht_vertical;
   logic             end_vertical_flag;
   logic             enable_absolute;
   logic             enable_sum;
   logic             end_sum_flag;

   modport master (
      output start, size8, stall,
      input  busy, done, size8_q, stage, count,
      input  enable_diff, shift_flag, enable_ht_horizontal, enable_shift_buffer,
      input  vertical_flag, enable_ht_vertical, end_vertical_flag,
      input  enable_absolute, enable_sum, end_sum_flag
   );

   modport slave (
      input  start, size8, stall,
      output busy, done, size8_q, stage, count,
      output enable_diff, shift_flag, enable_ht_horizontal, enable_shift_buffer,
      output vertical_flag, enable_ht_vertical, end_vertical_flag,
      output enable_absolute, enable_sum, end_sum_flag
   );
endinterface

// File: rtl/satd_strobe_decode.sv
// Pure decode of the active-cycle index into the datapath strobe vector.
// Windows are shifted by the transform latency so they may straddle stage boundaries.
module satd_strobe_decode
   import satd_pkg::*;
#(
   parameter int HT_LAT = 1
) (
   input  logic [AIDX_W-1:0] a,
   input  logic [AIDX_W-1:0] n,
   output strobe_t           strobes
);

   int ai;
   int ni;

   assign ai = int'(a);
   assign ni = int'(n);

   always_comb begin
      strobes = '0;
      strobes.shift_flag           = (ai <= ni);
      strobes.enable_diff          = (ai >= 1) && (ai <= ni);
      strobes.enable_ht_horizontal = (ai >= 1 + HT_LAT) && (ai <= ni + HT_LAT);
      strobes.enable_shift_buffer  = (ai >= 1 + HT_LAT) && (ai <= ni + HT_LAT);
      strobes.vertical_flag        = (ai >= ni + 1) && (ai <= 2*ni);
      strobes.enable_ht_vertical   = (ai >= ni + 1 + HT_LAT) && (ai <= 2*ni + HT_LAT);
      strobes.end_vertical_flag    = (ai == 2*ni + HT_LAT);
      strobes.enable_absolute      = (ai >= 2*ni + 1 + HT_LAT) && (ai <= 3*ni + HT_LAT);
      strobes.enable_sum           = (ai >= 2*ni + 1 + HT_LAT) && (ai <= 3*ni + HT_LAT + 1);
      strobes.end_sum_flag         = (ai == 3*ni + HT_LAT + 1);
   end

endmodule

// File: rtl/satd_control_param.sv
// SATD datapath sequencer: 4x4/8x8 blocks, start/busy/done handshake, stall freeze,
// all outputs registered from the next active-cycle index.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | no block, waiting for start
//   ST_PRIME  | a=0, shift buffer primed
//   ST_HORIZ  | a=1..N, diff feeding horizontal transform
//   ST_VERT   | a=N+1..2N, vertical pass
//   ST_SUM    | a=2N+1..3N+L+1, abs/sum drain
//   ST_DONE   | one-cycle done pulse; start here chains the next block
module satd_control_param
   import satd_pkg::*;
#(
   parameter int HT_LAT = 1,
   parameter int CNT_W  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   satd_control_param_if.slave  bus
);

   stage_t             stage_q;
   logic [AIDX_W-1:0]  a_q;
   logic [CNT_W-1:0]   count_q;
   logic               busy_q;
   logic               done_q;
   logic               size8_q;
   strobe_t            strobes_q;

   logic               accept;
   logic [AIDX_W-1:0]  a_nxt;
   logic [AIDX_W-1:0]  n_nxt;
   stage_t             stage_nxt;
   logic [CNT_W-1:0]   count_nxt;
   strobe_t            strobes_d;

   // busy is low exactly in IDLE and DONE, which are the accepting stages
   always_comb begin
      accept    = bus.start && !busy_q;
      n_nxt     = (accept ? bus.size8 : size8_q) ? AIDX_W'(N8) : AIDX_W'(N4);
      a_nxt     = accept ? '0 : a_q + AIDX_W'(1);
      stage_nxt = stage_of(int'(a_nxt), int'(n_nxt), HT_LAT);
      count_nxt = CNT_W'(count_of(int'(a_nxt), int'(n_nxt), HT_LAT));
   end

   satd_strobe_decode #(
      .HT_LAT (HT_LAT)
   ) u_strobe_decode (
      .a       (a_nxt),
      .n       (n_nxt),
      .strobes (strobes_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q   <= ST_IDLE;
         a_q       <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         size8_q   <= 1'b0;
         strobes_q <= '0;
      end else if (accept) begin
         stage_q   <= ST_PRIME;
         a_q       <= '0;
         count_q   <= '0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         size8_q   <= bus.size8;
         strobes_q <= strobes_d;
      end else if (busy_q && bus.stall) begin
         // frozen position: stage, count and a hold, strobes silenced
         strobes_q <= '0;
         done_q    <= 1'b0;
      end else if (busy_q) begin
         stage_q   <= stage_nxt;
         a_q       <= a_nxt;
         count_q   <= count_nxt;
         busy_q    <= (stage_nxt != ST_DONE);
         done_q    <= (stage_nxt == ST_DONE);
         strobes_q <= strobes_d;
      end else begin
         stage_q   <= ST_IDLE;
         a_q       <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         strobes_q <= '0;
      end
   end

   assign bus.busy                 = busy_q;
   assign bus.done                 = done_q;
   assign bus.size8_q              = size8_q;
   assign bus.stage                = stage_q;
   assign bus.count                = count_q;
   assign bus.enable_diff          = strobes_q.enable_diff;
   assign bus.shift_flag           = strobes_q.shift_flag;
   assign bus.enable_ht_horizontal = strobes_q.enable_ht_horizontal;
   assign bus.enable_shift_buffer  = strobes_q.enable_shift_buffer;
   assign bus.vertical_flag        = strobes_q.vertical_flag;
   assign bus.enable_ht_vertical   = strobes_q.enable_ht_vertical;
   assign bus.end_vertical_flag    = strobes_q.end_vertical_flag;
   assign bus.enable_absolute      = strobes_q.enable_absolute;
   assign bus.enable_sum           = strobes_q.enable_sum;
   assign bus.end_sum_flag         = strobes_q.end_sum_flag;

endmodule

// File: tb/tb_satd_control_param.sv
// Directed bench for satd_control_param: two instances (HT_LAT=1 and HT_LAT=2),
// per-cycle trace capture after each start, hand-computed expectations.
module tb_satd_control_param;
   import satd_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   satd_control_param_if #(.CNT_W(4)) bus1 ();
   satd_control_param_if #(.CNT_W(4)) bus2 ();

   satd_control_param #(.HT_LAT(1), .CNT_W(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   satd_control_param #(.HT_LAT(2), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

   typedef struct packed {
      logic       done;
      logic       busy;
      logic       size8_q;
      logic [2:0] stage;
      logic [3:0] count;
      logic [9:0] strb;
   } rec_t;

   // strobe bit positions in rec_t.strb; 10 = done, 11 = busy
   localparam int SB_DIFF = 9, SB_SHIFT = 8, SB_HTH = 7, SB_SBUF = 6, SB_VF = 5;
   localparam int SB_HTV = 4, SB_EVF = 3, SB_ABS = 2, SB_SUM = 1, SB_ESF = 0;
   localparam int SG_DONE = 10, SG_BUSY = 11;

   rec_t rec [0:63];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic rec_t grab(input bit use2);
      rec_t r;
      if (use2)
         r = '{done: bus2.done, busy: bus2.busy, size8_q: bus2.size8_q, stage: bus2.stage,
               count: bus2.count,
               strb: {bus2.enable_diff, bus2.shift_flag, bus2.enable_ht_horizontal,
                      bus2.enable_shift_buffer, bus2.vertical_flag, bus2.enable_ht_vertical,
                      bus2.end_vertical_flag, bus2.enable_absolute, bus2.enable_sum,
                      bus2.end_sum_flag}};
      else
         r = '{done: bus1.done, busy: bus1.busy, size8_q: bus1.size8_q, stage: bus1.stage,
               count: bus1.count,
               strb: {bus1.enable_diff, bus1.shift_flag, bus1.enable_ht_horizontal,
                      bus1.enable_shift_buffer, bus1.vertical_flag, bus1.enable_ht_vertical,
                      bus1.end_vertical_flag, bus1.enable_absolute, bus1.enable_sum,
                      bus1.end_sum_flag}};
      return r;
   endfunction

   task automatic drive(input bit use2, input logic st, input logic sz, input logic stl);
      if (use2) begin
         bus2.start = st; bus2.size8 = sz; bus2.stall = stl;
      end else begin
         bus1.start = st; bus1.size8 = sz; bus1.stall = stl;
      end
   endtask

   // Called at a negedge; start is sampled at the next posedge (edge k),
   // rec[t] holds outputs of cycle k+t.
   task automatic capture(input bit use2, input int n_cyc, input logic sz, input bit hold_start,
                          input int stall_from, input int stall_len, input int toggle_at);
      logic s = sz;
      drive(use2, 1'b1, s, 1'b0);
      for (int t = 1; t <= n_cyc; t++) begin
         @(negedge clk);
         rec[t] = grab(use2);
         if (t == toggle_at) s = ~s;
         drive(use2, hold_start, s,
               (t >= stall_from) && (t < stall_from + stall_len) && (stall_len > 0));
      end
      drive(use2, 1'b0, s, 1'b0);
   endtask

   function automatic logic sig(input int t, input int idx);
      if (idx == SG_DONE) return rec[t].done;
      if (idx == SG_BUSY) return rec[t].busy;
      return rec[t].strb[idx];
   endfunction

   function automatic int count_hi(input int idx, input int n_cyc);
      int c = 0;
      for (int t = 1; t <= n_cyc; t++) if (sig(t, idx)) c++;
      return c;
   endfunction

   function automatic int first_hi(input int idx, input int n_cyc);
      for (int t = 1; t <= n_cyc; t++) if (sig(t, idx)) return t;
      return 0;
   endfunction

   task automatic wait_idle(input bit use2, input int bound, input string tag);
      rec_t r;
      r = grab(use2);
      for (int i = 0; i < bound && r.stage != ST_IDLE; i++) begin
         @(negedge clk);
         r = grab(use2);
      end
      chk(tag, r.stage, ST_IDLE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("reset_outputs_l1", grab(1'b0), '0);
      chk("reset_outputs_l2", grab(1'b1), '0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", grab(1'b0), '0);

      // 1: N=4, L=1
      capture(1'b0, 20, 1'b0, 1'b0, 0, 0, 0);
      chk("t1_prime_stage", rec[1].stage, ST_PRIME);
      chk("t1_prime_busy", rec[1].busy, 1);
      chk("t1_prime_shift", rec[1].strb, 10'b0100000000);
      chk("t1_done_first", first_hi(SG_DONE, 20), 16);
      chk("t1_done_count", count_hi(SG_DONE, 20), 1);
      chk("t1_diff_count", count_hi(SB_DIFF, 20), 4);
      chk("t1_diff_first", first_hi(SB_DIFF, 20), 2);
      chk("t1_sum_count", count_hi(SB_SUM, 20), 5);
      chk("t1_sum_first", first_hi(SB_SUM, 20), 11);
      chk("t1_vert_count_a6", rec[7].count, 1);
      chk("t1_busy_in_done", rec[16].busy, 0);
      chk("t1_idle_after_done", rec[17].stage, ST_IDLE);

      // 2: N=8, L=1
      capture(1'b0, 32, 1'b1, 1'b0, 0, 0, 0);
      chk("t2_size8_q", rec[1].size8_q, 1);
      chk("t2_done_first", first_hi(SG_DONE, 32), 28);
      chk("t2_done_count", count_hi(SG_DONE, 32), 1);
      chk("t2_vflag_count", count_hi(SB_VF, 32), 8);
      chk("t2_vflag_first", first_hi(SB_VF, 32), 10);
      chk("t2_endv_count", count_hi(SB_EVF, 32), 1);
      chk("t2_endv_first", first_hi(SB_EVF, 32), 18);
      chk("t2_ends_count", count_hi(SB_ESF, 32), 1);
      chk("t2_ends_first", first_hi(SB_ESF, 32), 27);
      chk("t2_sum_count_max", rec[27].count, 9);

      // 3: N=4, stall three cycles while a=5 is shown
      capture(1'b0, 24, 1'b0, 1'b0, 6, 3, 0);
      chk("t3_a5_strobes", rec[6].strb, 10'b0011100000);
      chk("t3_stall_strobes", rec[7].strb | rec[8].strb | rec[9].strb, 0);
      chk("t3_stall_stage", rec[9].stage, ST_VERT);
      chk("t3_stall_count", rec[9].count, 0);
      chk("t3_stall_busy", rec[8].busy, 1);
      chk("t3_resume_strobes", rec[10].strb, 10'b0000110000);
      chk("t3_resume_count", rec[10].count, 1);
      chk("t3_done_first", first_hi(SG_DONE, 24), 19);
      chk("t3_done_count", count_hi(SG_DONE, 24), 1);

      // 4: N=4, start held high
      capture(1'b0, 40, 1'b0, 1'b1, 0, 0, 0);
      chk("t4_ignore_busy_start", rec[5].stage, ST_HORIZ);
      chk("t4_ignore_busy_count", rec[5].count, 3);
      chk("t4_done_first", first_hi(SG_DONE, 40), 16);
      chk("t4_done_count", count_hi(SG_DONE, 40), 2);
      chk("t4_done_second", rec[32].done, 1);
      chk("t4_chain_prime1", rec[17].stage, ST_PRIME);
      chk("t4_chain_prime2", rec[33].stage, ST_PRIME);
      wait_idle(1'b0, 30, "t4_drain_idle");

      // 5: reset while a=9 is shown
      capture(1'b0, 10, 1'b0, 1'b0, 0, 0, 0);
      chk("t5_pre_reset_stage", rec[10].stage, ST_SUM);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_after_reset", grab(1'b0), '0);
      reset = 1'b0;
      @(negedge clk);
      chk("t5_no_done", grab(1'b0), '0);
      capture(1'b0, 20, 1'b0, 1'b0, 0, 0, 0);
      chk("t5_restart_done_first", first_hi(SG_DONE, 20), 16);
      chk("t5_restart_done_count", count_hi(SG_DONE, 20), 1);

      // 6: HT_LAT=2, N=8, size8 toggled mid-block
      capture(1'b1, 32, 1'b1, 1'b0, 0, 0, 5);
      chk("t6_hth_first", first_hi(SB_HTH, 32), 4);
      chk("t6_hth_count", count_hi(SB_HTH, 32), 8);
      chk("t6_endv_first", first_hi(SB_EVF, 32), 19);
      chk("t6_done_first", first_hi(SG_DONE, 32), 29);
      chk("t6_done_count", count_hi(SG_DONE, 32), 1);
      chk("t6_size8_q_held", rec[20].size8_q, 1);
      chk("t6_sum_count_max", rec[28].count, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
